// File: rtl/avg_window_if.sv
// Sample-in / mean-out bundle for avg_window. The producer side drives samples
// and control; the averager side returns the per-channel means.
interface avg_window_if #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned N_CH     = 1,
  parameter int unsigned LOG2_LEN = 4
);
  logic                     mode;
  logic                     clear;
  logic                     in_valid;
  logic [N_CH*DATA_W-1:0]   in_data;
  logic [N_CH*DATA_W-1:0]   avg_data;
  logic                     avg_valid;
  logic [LOG2_LEN:0]        fill_cnt;

  modport master (
    output mode, clear, in_valid, in_data,
    input  avg_data, avg_valid, fill_cnt
  );

  modport slave (
    input  mode, clear, in_valid, in_data,
    output avg_data, avg_valid, fill_cnt
  );
endinterface

// File: rtl/avg_window.sv
// Multi-channel power-of-two window averager, block (decimating) or running
// (boxcar) mode. One-cycle avg_valid strobe per result; avg_data holds between.
module avg_window #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned N_CH     = 1,
  parameter int unsigned LOG2_LEN = 4
) (
  input  logic          clk,
  input  logic          rstn,
  avg_window_if.slave   bus
);

  localparam int unsigned LEN    = 2 ** LOG2_LEN;
  localparam int unsigned ACC_W  = DATA_W + LOG2_LEN;
  localparam int unsigned FILL_W = LOG2_LEN + 1;
  localparam int unsigned PTR_W  = LOG2_LEN;

  logic                   init_q;
  logic                   mode_q;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   valid_q, strobe;
  logic [N_CH*DATA_W-1:0] avg_q, avg_d;
  logic [ACC_W-1:0]       acc_q [N_CH];
  logic [ACC_W-1:0]       acc_d [N_CH];
  logic [ACC_W-1:0]       samp  [N_CH];
  logic [ACC_W-1:0]       oldest[N_CH];
  logic [ACC_W-1:0]       sum   [N_CH];
  logic [DATA_W-1:0]      win_q [N_CH][LEN];

  logic mode_eff, flush, accept, full, wr_en;

  // Flush decision and next-state for accumulators, fill, pointer and result
  always_comb begin
    // Before the first post-reset edge mode_q is not meaningful; take mode as-is.
    mode_eff = init_q ? mode_q : bus.mode;
    flush    = bus.clear | (bus.mode != mode_eff);
    accept   = bus.in_valid & ~flush;
    full     = (fill_q == FILL_W'(LEN));
    fill_d   = fill_q;
    ptr_d    = ptr_q;
    avg_d    = avg_q;
    strobe   = 1'b0;
    wr_en    = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      samp[k]   = ACC_W'(bus.in_data[k*DATA_W +: DATA_W]);
      oldest[k] = full ? ACC_W'(win_q[k][ptr_q]) : '0;
      sum[k]    = '0;
      acc_d[k]  = acc_q[k];
    end

    if (flush) begin
      fill_d = '0;
      ptr_d  = '0;
      for (int k = 0; k < N_CH; k++) acc_d[k] = '0;
    end else if (accept) begin
      if (!mode_eff) begin
        if (fill_q == FILL_W'(LEN - 1)) begin
          strobe = 1'b1;
          fill_d = '0;
        end else begin
          fill_d = fill_q + FILL_W'(1);
        end
        for (int k = 0; k < N_CH; k++) begin
          sum[k]   = acc_q[k] + samp[k];
          acc_d[k] = strobe ? '0 : sum[k];
          if (strobe) avg_d[k*DATA_W +: DATA_W] = DATA_W'(sum[k] >> LOG2_LEN);
        end
      end else begin
        wr_en  = 1'b1;
        ptr_d  = ptr_q + PTR_W'(1);
        fill_d = full ? fill_q : fill_q + FILL_W'(1);
        strobe = full | (fill_q == FILL_W'(LEN - 1));
        for (int k = 0; k < N_CH; k++) begin
          // Subtract first: acc >= oldest, so the intermediate never overflows.
          sum[k]   = acc_q[k] - oldest[k] + samp[k];
          acc_d[k] = sum[k];
          if (strobe) avg_d[k*DATA_W +: DATA_W] = DATA_W'(sum[k] >> LOG2_LEN);
        end
      end
    end
  end

  // Control and accumulator state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      init_q  <= 1'b0;
      mode_q  <= 1'b0;
      fill_q  <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      avg_q   <= '0;
      for (int k = 0; k < N_CH; k++) acc_q[k] <= '0;
    end else begin
      init_q  <= 1'b1;
      mode_q  <= bus.mode;
      fill_q  <= fill_d;
      ptr_q   <= ptr_d;
      valid_q <= strobe;
      avg_q   <= avg_d;
      for (int k = 0; k < N_CH; k++) acc_q[k] <= acc_d[k];
    end
  end

  // Running-mode sample history; never reset, fill gating hides stale entries
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < N_CH; k++) win_q[k][ptr_q] <= bus.in_data[k*DATA_W +: DATA_W];
    end
  end

  // Registered outputs
  always_comb begin
    bus.avg_data  = avg_q;
    bus.avg_valid = valid_q;
    bus.fill_cnt  = fill_q;
  end

endmodule

// File: doc/avg_window.md
# avg_window

Parametrised multi-channel averager for the acquisition path. It takes unsigned samples under a valid qualifier and produces a per-channel mean over a power-of-two window, in either block (decimating) or running (boxcar) mode. A one-cycle `avg_valid` strobe accompanies each result, so the strobe can drive the `sample` input of the downstream sample-and-hold directly.

## Interface
- `DATA_W`, 16: sample and result width per channel, unsigned.
- `N_CH`, 1: number of independent channels, 1..8.
- `LOG2_LEN`, 4: window length is 2^LOG2_LEN samples, 1..8.

Ports:
- `clk`  in  1  single clock domain; all logic is rising-edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `mode`  in  1  0 = block average, 1 = running average.
- `clear`  in  1  synchronous flush of the window.
- `in_valid`  in  1  `in_data` is accepted on this cycle.
- `in_data`  in  N_CH*DATA_W  channel k occupies [k*DATA_W +: DATA_W].
- `avg_data`  out  N_CH*DATA_W  per-channel mean, same packing; holds its value between strobes.
- `avg_valid`  out  1  one-cycle strobe marking a new `avg_data`.
- `fill_cnt`  out  LOG2_LEN+1  number of samples currently in the window.

## Operation
- The accumulator per channel is DATA_W+LOG2_LEN bits wide and can never overflow.
- Result = acc >> LOG2_LEN, truncating (floor).
- The internal registered mode `mode_q` follows `mode`.
- When `mode` differs from `mode_q`, or when `clear` = 1, the block flushes:
  - acc, fill count and write pointer go to 0;
  - `in_valid` on that cycle is discarded;
  - no strobe is issued;
  - `avg_data` keeps its last value.
- Flush has priority over `in_valid`.

Block mode (`mode_q` = 0):
- Each accepted sample: acc += x; fill += 1.
- When the 2^LOG2_LEN-th sample is accepted:
  - `avg_data` <= (acc + x) >> LOG2_LEN;
  - acc <= 0; fill <= 0.
- `fill_cnt` ranges 0..2^LOG2_LEN-1. Results are decimated by 2^LOG2_LEN.

Running mode (`mode_q` = 1):
- Each channel has a circular buffer of depth 2^LOG2_LEN and one shared write pointer.
- Each accepted sample:
  - oldest = buf[ptr] when the window is full, else 0;
  - acc <= acc + x - oldest;
  - buf[ptr] <= x;
  - ptr increments and wraps from 2^LOG2_LEN-1 to 0.
- `fill_cnt` saturates at 2^LOG2_LEN.
- No output is produced while filling.
- When the accepted sample makes or keeps the window full, `avg_data` <= (new acc) >> LOG2_LEN.
- Buffer contents are not reset. Unwritten entries are never read, because the fill gating ensures this.

All channels share the valid, fill count and pointer, and they always strobe together.

## Timing
- Reset (`rstn` = 0, asynchronous, applies immediately, including mid-window):
  - `avg_data` = 0, `avg_valid` = 0, `fill_cnt` = 0;
  - acc = 0, ptr = 0, `mode_q` = `mode` sampled at the first post-reset edge.
- Latency: `avg_valid` rises on the cycle after the edge that accepts the qualifying sample. `avg_data` changes on that same edge.
- `avg_valid` is high for exactly one cycle per qualifying sample. It is never high on a cycle following a non-accepted input.
- Back-to-back `in_valid` gives one result per cycle in running mode once full, and one per 2^LOG2_LEN samples in block mode.
- Gaps in `in_valid` are allowed at any time. They stall the window without changing its state.
- `fill_cnt` is registered and reflects the state after the most recent edge.

## Test plan
1. Reset, then constant sample, block mode:
   - Stimulus: `rstn` low for 22 ns, then `in_data` = 65535 with `in_valid` held high, LOG2_LEN = 4.
   - Response: outputs are 0 during reset. `avg_valid` pulses one cycle after the 16th sample, then every 16 cycles, with `avg_data` = 65535.
2. Ramp with truncation, block mode:
   - Stimulus: samples 0..15.
   - Response: `avg_data` = 7 (120/16 floored), and `fill_cnt` returns to 0.
3. Step input, running mode:
   - Stimulus: 16 samples of 100, then 200s.
   - Response: first strobe after the 16th sample gives 100. After k samples of 200, the output is floor((100*(16-k)+200*k)/16), e.g. k = 3 gives 118. From k = 16 onward the output is 200. A strobe occurs on every accepted sample.
4. Sparse valid:
   - Stimulus: `in_valid` on every third cycle, repeating scenario 2 and scenario 3.
   - Response: identical results. Strobes occur only one cycle after accepted samples.
5. Flush behaviour:
   - Stimulus: `clear` after 10 block samples, with `in_valid` asserted in the same cycle.
   - Response: the sample is discarded and `fill_cnt` = 0. The next strobe requires 16 fresh samples.
   - Toggling `mode` mid-window flushes the same way.
   - `rstn` low mid-window zeroes all outputs immediately.
6. Multi-channel:
   - Stimulus: N_CH = 2, ch0 = 1000, ch1 = 3 constant, running mode.
   - Response: the strobe carries `avg_data` = {16'd3, 16'd1000}, and the channels never cross-talk.
